// File: rtl/hs_link_pkg.sv
// Shared definitions for the 4-phase req/ack CDC link (sender and receiver sides).
package hs_link_pkg;

    localparam int HS_DATA_W = 4;
    localparam int HS_CNT_W  = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } hs_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// N-flop single-bit synchronizer; output is the last stage, all stages reset to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hs_data_receiver.sv
// Receiving half of a 4-phase req/ack CDC link: sync req, capture data once per
// req-high phase, acknowledge, and publish word, count and sequence-error flag.
module hs_data_receiver
    import hs_link_pkg::*;
#(
    parameter int DATA_W      = HS_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = HS_CNT_W
) (
    input  logic              clkb,
    input  logic              rst_n,
    input  logic              data_req,
    input  logic [DATA_W-1:0] data,
    output logic              data_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [CNT_W-1:0]  rx_count,
    output logic              seq_err
);

    logic req_s;

    hs_state_e         state_q, state_d;
    logic              data_ack_q, data_ack_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0]  rx_count_q, rx_count_d;
    logic              seq_err_q, seq_err_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] expect_data;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clkb),
        .rst_n (rst_n),
        .d     (data_req),
        .q     (req_s)
    );

    assign expect_data = rx_data_q + DATA_W'(1);

    always_comb begin
        state_d    = state_q;
        data_ack_d = data_ack_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_count_d = rx_count_q;
        seq_err_d  = seq_err_q;
        first_d    = first_q;
        case (state_q)
            ST_IDLE: begin
                // data is unsynchronized; the sender holds it stable while req is high
                if (req_s) begin
                    rx_data_d  = data;
                    rx_valid_d = 1'b1;
                    data_ack_d = 1'b1;
                    rx_count_d = rx_count_q + CNT_W'(1);
                    first_d    = 1'b0;
                    if (!first_q && (data != expect_data)) begin
                        seq_err_d = 1'b1;
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    data_ack_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                data_ack_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_ack_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_count_q <= '0;
            seq_err_q  <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_ack_q <= data_ack_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_count_q <= rx_count_d;
            seq_err_q  <= seq_err_d;
            first_q    <= first_d;
        end
    end

    assign data_ack = data_ack_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_count = rx_count_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_hs_data_receiver.sv
// Directed bench for hs_data_receiver: sender modelled on clka, receiver on clkb.
module tb_hs_data_receiver;

    logic       clka = 1'b0;
    logic       clkb = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_req = 1'b0;
    logic [3:0] data = 4'h0;
    logic       data_ack;
    logic [3:0] rx_data;
    logic       rx_valid;
    logic [7:0] rx_count;
    logic       seq_err;

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;

    always #5  clka = ~clka;
    always #10 clkb = ~clkb;

    // Each rx_valid pulse spans exactly one negedge of clkb.
    always @(negedge clkb) if (rx_valid === 1'b1) valid_cnt++;

    hs_data_receiver #(
        .DATA_W      (4),
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .clkb     (clkb),
        .rst_n    (rst_n),
        .data_req (data_req),
        .data     (data),
        .data_ack (data_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_count (rx_count),
        .seq_err  (seq_err)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        data_req = 1'b0;
        data = 4'h0;
        repeat (2) @(posedge clkb);
        @(negedge clkb);
        rst_n = 1'b1;
        @(negedge clkb);
    endtask

    task automatic wait_ack(input logic lvl, output int edges);
        edges = 0;
        while (data_ack !== lvl && edges < 20) begin
            @(posedge clkb); #1;
            edges++;
        end
        n_vec++;
        if (data_ack !== lvl) begin
            n_err++;
            $display("FAIL wait_ack: data_ack=%b required %b within 20 clkb edges", data_ack, lvl);
        end
    endtask

    task automatic send_word(input logic [3:0] d);
        int e;
        @(posedge clka); #1;
        data = d;
        data_req = 1'b1;
        wait_ack(1'b1, e);
        @(posedge clka); #1;
        data_req = 1'b0;
        wait_ack(1'b0, e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        data = 4'h9;
        data_req = 1'b1;
        repeat (3) @(posedge clkb);
        @(negedge clkb);
        n_vec++;
        if ({data_ack, rx_data, rx_valid, rx_count, seq_err} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b data=%h vld=%b cnt=%0d err=%b required all 0",
                     data_ack, rx_data, rx_valid, rx_count, seq_err);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clkb);
        #1;
        n_vec++;
        if (data_ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_early_ack: data_ack=%b at edge 2 required 0", data_ack);
        end
        @(posedge clkb); #1;
        n_vec++;
        if ({data_ack, rx_valid, rx_data, rx_count} !== {1'b1, 1'b1, 4'h9, 8'd1}) begin
            n_err++;
            $display("FAIL reset_capture_edge3: ack=%b vld=%b data=%h cnt=%0d required 1 1 9 1",
                     data_ack, rx_valid, rx_data, rx_count);
        end
        @(posedge clka); #1;
        data_req = 1'b0;
        begin
            int e;
            wait_ack(1'b0, e);
        end
    endtask

    task automatic test_single();
        int e;
        do_reset();
        @(posedge clka); #1;
        data = 4'h5;
        data_req = 1'b1;
        wait_ack(1'b1, e);
        n_vec++;
        if (e < 2 || e > 3) begin
            n_err++;
            $display("FAIL single_ack_latency: %0d edges required 2..3", e);
        end
        n_vec++;
        if ({rx_valid, rx_data, rx_count} !== {1'b1, 4'h5, 8'd1}) begin
            n_err++;
            $display("FAIL single_capture: vld=%b data=%h cnt=%0d required 1 5 1", rx_valid, rx_data, rx_count);
        end
        @(posedge clkb); #1;
        n_vec++;
        if ({rx_valid, data_ack} !== 2'b01) begin
            n_err++;
            $display("FAIL single_pulse_width: vld=%b ack=%b required 0 1", rx_valid, data_ack);
        end
        @(posedge clka); #1;
        data_req = 1'b0;
        wait_ack(1'b0, e);
        n_vec++;
        if (e > 3) begin
            n_err++;
            $display("FAIL single_ack_release: %0d edges required <=3", e);
        end
    endtask

    task automatic test_sequence();
        int v0;
        logic [3:0] w;
        do_reset();
        v0 = valid_cnt;
        for (int i = 0; i < 24; i++) begin
            w = 4'(i);
            send_word(w);
        end
        @(negedge clkb);
        n_vec++;
        if ({rx_count, seq_err, rx_data} !== {8'd24, 1'b0, 4'h7}) begin
            n_err++;
            $display("FAIL sequence_state: cnt=%0d err=%b data=%h required 24 0 7", rx_count, seq_err, rx_data);
        end
        n_vec++;
        if (valid_cnt - v0 !== 24) begin
            n_err++;
            $display("FAIL sequence_pulses: %0d rx_valid pulses required 24", valid_cnt - v0);
        end
    endtask

    task automatic test_seq_break();
        do_reset();
        send_word(4'h3);
        n_vec++;
        if (seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL break_first_word: seq_err=%b required 0", seq_err);
        end
        send_word(4'h5);
        n_vec++;
        if (seq_err !== 1'b1) begin
            n_err++;
            $display("FAIL break_detect: seq_err=%b required 1", seq_err);
        end
        send_word(4'h6);
        send_word(4'h7);
        n_vec++;
        if ({seq_err, rx_count} !== {1'b1, 8'd4}) begin
            n_err++;
            $display("FAIL break_sticky: seq_err=%b cnt=%0d required 1 4", seq_err, rx_count);
        end
        do_reset();
        n_vec++;
        if (seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL break_cleared: seq_err=%b required 0 after reset", seq_err);
        end
    endtask

    task automatic test_long_req();
        int e, v0, drops;
        do_reset();
        v0 = valid_cnt;
        drops = 0;
        @(posedge clka); #1;
        data = 4'hA;
        data_req = 1'b1;
        wait_ack(1'b1, e);
        for (int i = 0; i < 50; i++) begin
            @(posedge clkb); #1;
            if (data_ack !== 1'b1) drops++;
        end
        n_vec++;
        if (drops !== 0) begin
            n_err++;
            $display("FAIL long_ack_held: ack low in %0d cycles required 0", drops);
        end
        n_vec++;
        if ({valid_cnt - v0 == 1, rx_count} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL long_single_capture: pulses=%0d cnt=%0d required 1 1", valid_cnt - v0, rx_count);
        end
        @(posedge clka); #1;
        data_req = 1'b0;
        wait_ack(1'b0, e);
    endtask

    task automatic test_count_wrap();
        logic [3:0] w;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            w = 4'(i);
            send_word(w);
        end
        n_vec++;
        if ({rx_count, seq_err, rx_data} !== {8'd0, 1'b0, 4'hF}) begin
            n_err++;
            $display("FAIL count_wrap: cnt=%0d err=%b data=%h required 0 0 f", rx_count, seq_err, rx_data);
        end
        send_word(4'h0);
        n_vec++;
        if ({rx_count, seq_err} !== {8'd1, 1'b0}) begin
            n_err++;
            $display("FAIL count_after_wrap: cnt=%0d err=%b required 1 0 (F->0 legal)", rx_count, seq_err);
        end
    endtask

    task automatic test_reset_mid();
        int e, v0;
        do_reset();
        send_word(4'h3);
        send_word(4'h5);
        @(posedge clka); #1;
        data = 4'h6;
        data_req = 1'b1;
        wait_ack(1'b1, e);
        #5 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({data_ack, rx_count, seq_err, rx_valid} !== 11'd0) begin
            n_err++;
            $display("FAIL mid_reset_async: ack=%b cnt=%0d err=%b vld=%b required all 0",
                     data_ack, rx_count, seq_err, rx_valid);
        end
        @(posedge clkb);
        @(negedge clkb);
        v0 = valid_cnt;
        rst_n = 1'b1;
        repeat (10) @(posedge clkb);
        #1;
        n_vec++;
        if ({valid_cnt - v0 == 1, data_ack, rx_data, rx_count, seq_err} !== {1'b1, 1'b1, 4'h6, 8'd1, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset_recapture: pulses=%0d ack=%b data=%h cnt=%0d err=%b required 1 1 6 1 0",
                     valid_cnt - v0, data_ack, rx_data, rx_count, seq_err);
        end
        @(posedge clka); #1;
        data_req = 1'b0;
        wait_ack(1'b0, e);
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_seq_break();
        test_long_req();
        test_count_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hs_data_receiver.md
Name: hs_data_receiver

Overview:
- Receiving half of a 4-phase req/ack clock-domain-crossing link; runs entirely in the clkb domain.
- A peer sender in an unrelated clock domain drives data_req and a 4-bit data bus, and holds data stable while data_req is high.
- Block synchronizes data_req, captures data, returns data_ack, and publishes each received word with a valid pulse, a word counter and a sequence-error flag.

Parameters:
- DATA_W, 4, width of data bus and rx_data
- SYNC_STAGES, 2, flops in data_req synchronizer (legal range 2..4)
- CNT_W, 8, width of rx_count

Ports:
- clkb  in  1  receiver clock, rising edge; single clock of the block
- rst_n  in  1  asynchronous active-low reset; clears all state immediately
- data_req  in  1  request from sender, asynchronous to clkb
- data  in  DATA_W  sender data; stable from data_req rise until data_ack seen high
- data_ack  out  1  acknowledge to sender, registered, glitch-free
- rx_data  out  DATA_W  last captured word, held until next capture
- rx_valid  out  1  one-cycle pulse when rx_data updates
- rx_count  out  CNT_W  number of words received, wraps modulo 2^CNT_W
- seq_err  out  1  sticky flag: a received word broke the +1 sequence

Behaviour:
- Reset values: data_ack=0, rx_data=0, rx_valid=0, rx_count=0, seq_err=0, synchronizer flops=0, FSM=IDLE, first-word flag set.
- data_req passes through SYNC_STAGES flops; req_s is the last stage. No other logic uses raw data_req.
- data is sampled only in the capture cycle. It is not synchronized; the protocol guarantees stability.
- FSM states:
  - IDLE: data_ack=0.
    - On a clkb edge with req_s=1: rx_data<=data, rx_valid<=1, data_ack<=1, rx_count<=rx_count+1, go to ACK.
  - ACK: data_ack=1.
    - Stay while req_s=1.
    - On an edge with req_s=0: data_ack<=0, go to IDLE.
- Latency with SYNC_STAGES=2:
  - data_req rises before clkb edge n.
  - req_s=1 after edge n+1.
  - Capture and data_ack=1 at edge n+2.
  - Deassert mirrors this: data_ack falls 2 edges after data_req fall is first sampled.
- rx_valid is high exactly one cycle per handshake, never in ACK beyond its entry cycle.
- Exactly one capture per data_req high phase, however long data_req stays high.
- A new request is accepted only after data_ack has returned to 0 (back in IDLE).
- Sequence check, performed at each capture:
  - First capture after reset: no check; clears the first-word flag.
  - Later captures: if data != (previous rx_data + 1) mod 2^DATA_W, set seq_err.
  - seq_err is sticky until reset.
  - Wrap 4'hF -> 4'h0 is a legal sequence.
- rx_count wraps from 2^CNT_W-1 to 0 without error.
- Reset mid-handshake: data_ack drops asynchronously. The sender must restart its handshake from req low. A req still high after reset release is treated as a new request and captured once.
- Glitch on data_req shorter than a clkb period may be missed or captured once. Never captured twice.

Decomposition:
- Shared package hs_link_pkg:
  - DATA_W default, CNT_W default.
  - FSM state enum (IDLE, ACK), 1-bit encoding.
  - A sender-side package user can reuse DATA_W.
- One sub-module: bit_synchronizer (parameter STAGES). N-flop single-bit synchronizer, async active-low reset to 0. Reused by the sender for data_ack.

Test Plan:
- Reset: hold rst_n=0 with data_req=1.
  - Required: all outputs 0.
  - After release: capture once at edge 3, data_ack=1.
- Single word: clka 10 ns / clkb 20 ns; sender drives data=4'h5, raises data_req.
  - Required: data_ack=1 two-to-three clkb edges later, rx_data=5, rx_valid 1 cycle, rx_count=1.
  - After req drops, data_ack=0 within 3 clkb edges.
- Sequence 0..F then 0..7 (24 words) with a correct 4-phase sender.
  - Required: rx_count=24, seq_err=0, rx_valid pulsed 24 times, final rx_data=7.
- Sequence break: send 3 then 5.
  - Required: seq_err=1 after capture of 5, stays 1 through further correct words until reset.
- Long req: hold data_req high 50 clkb cycles.
  - Required: exactly one rx_valid, data_ack high throughout, rx_count+1.
- Reset mid-handshake: assert rst_n=0 while in ACK.
  - Required: data_ack=0 immediately, rx_count=0, seq_err=0.
